// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : ALU op-codes and arbiter state encoding shared by the block.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_XOR  = 4'd3;
  localparam logic [3:0] ALU_NOR  = 4'd4;
  localparam logic [3:0] ALU_NAND = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd12;
  localparam logic [3:0] ALU_SRL  = 4'd13;
  localparam logic [3:0] ALU_SRA  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter_if : requester-side request/response bundle.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*CTRL_W-1:0] req_control;
  logic [NUM_REQ*DATA_W-1:0] req_source_A;
  logic [NUM_REQ*DATA_W-1:0] req_source_B;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [DATA_W-1:0]         resp_result;
  logic                      resp_zero;

  modport master (
    output req_valid, req_control, req_source_A, req_source_B, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_zero
  );

  modport slave (
    input  req_valid, req_control, req_source_A, req_source_B, resp_ready,
    output req_ready, resp_valid, resp_result, resp_zero
  );

endinterface

`default_nettype wire

// File: rtl/alu_share_arbiter_rr_grant.sv
// ----------------------------------------------------------------------------
// rr_grant : combinational round-robin picker, first request at or above ptr.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_grant #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant
);

  logic [PTR_W:0] w_idx;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Extra index bit keeps ptr+k from overflowing before the wrap.
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(N)) begin
        w_idx = w_idx - (PTR_W+1)'(N);
      end
      if (!w_found && i_req[w_idx[PTR_W-1:0]]) begin
        o_grant[w_idx[PTR_W-1:0]] = 1'b1;
        w_found                   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one external ALU between NUM_REQ
// requesters. Optional macro ALU_LOCAL_ZERO_EN derives the zero flag locally.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [CTRL_W-1:0]   alu_control,
  output logic [DATA_W-1:0]   alu_source_A,
  output logic [DATA_W-1:0]   alu_source_B,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero
);

  import alu_pkg::*;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t          r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [PTR_W-1:0]    r_owner;
  logic [CTRL_W-1:0]   r_op_ctrl;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_zero;
  logic [NUM_REQ-1:0]  r_resp_valid;

  logic [NUM_REQ-1:0]  w_grant;
  logic [PTR_W-1:0]    w_gidx;
  logic [PTR_W-1:0]    w_next_ptr;
  logic                w_accept;
  logic                w_zero_in;
  logic [NUM_REQ-1:0]  w_owner_oh;
  logic [CTRL_W-1:0]   w_sel_ctrl;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;

  rr_grant #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gidx = PTR_W'(i);
      end
    end
  end

  assign w_next_ptr = (w_gidx == PTR_W'(NUM_REQ-1)) ? '0 : w_gidx + PTR_W'(1);
  assign w_sel_ctrl = bus.req_control [w_gidx*CTRL_W +: CTRL_W];
  assign w_sel_a    = bus.req_source_A[w_gidx*DATA_W +: DATA_W];
  assign w_sel_b    = bus.req_source_B[w_gidx*DATA_W +: DATA_W];
  assign w_owner_oh = NUM_REQ'(1) << r_owner;

  assign w_accept = (r_state == ST_IDLE) && (|w_grant);

  // Grant is combinational; rst_n gating keeps req_ready low while held in reset.
  assign bus.req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : '0;

`ifdef ALU_LOCAL_ZERO_EN
  logic w_unused_alu_zero;
  assign w_unused_alu_zero = alu_zero;
  assign w_zero_in         = (alu_result == '0);
`else
  assign w_zero_in = alu_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_owner      <= '0;
      r_op_ctrl    <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_result     <= '0;
      r_zero       <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op_ctrl <= w_sel_ctrl;
            r_op_a    <= w_sel_a;
            r_op_b    <= w_sel_b;
            r_owner   <= w_gidx;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result     <= alu_result;
          r_zero       <= w_zero_in;
          r_resp_valid <= w_owner_oh;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner's resp_ready can retire the response.
          if (bus.resp_ready[r_owner]) begin
            r_resp_valid <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= '0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_result = r_result;
  assign bus.resp_zero   = r_zero;

  assign alu_control  = r_op_ctrl;
  assign alu_source_A = r_op_a;
  assign alu_source_B = r_op_b;

endmodule

`default_nettype wire
